// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg: shared types and constants for the pipeline hazard controller.
//   hz_state_t : sequencing FSM states (RUN=0, FLUSH=1, MWAIT=2)
//   RA_W       : default register address width
//   REG_ZERO   : architectural zero register (never a real dependency)
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int RA_W = 5;

  localparam logic [RA_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    MWAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hz_perf_cnt.sv
// ---------------------------------------------------------------------------
// hz_perf_cnt: 32-bit event counter, counts once per cycle while en is high.
// Wraps at 2^32 and clears on reset.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   en     in   count enable for this cycle
//   count  out  current count
// ---------------------------------------------------------------------------
module hz_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl: sequencing controller for the IF/ID, ID/EX and EX/MEM
// pipeline registers of a 5-stage pipe.
//   - load-use hazard: 1-cycle stall of PC and IF/ID, bubble into ID/EX
//   - taken branch in EX: squash IF/ID and ID/EX for FLUSH_CYCLES cycles
//   - data memory busy: freeze PC/IF/ID and hold ID/EX + EX/MEM
// Priority each cycle: mem_wait > ex_branch_tkn > load-use.
// All control outputs are combinational from state and current inputs.
//
// Handshake: mem_wait is a level "not ready" from data memory; while it is
// high pipe_hold=1 and nothing upstream advances. The cycle it drops the
// pipe advances and hazards are evaluated normally in that same cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   id_rs, id_rt          source registers of the instruction in ID
//   id_uses_rt            ID instruction reads rt
//   ex_mem_read, ex_rt    load in EX and its destination register
//   ex_branch_tkn         branch resolved taken in EX
//   mem_wait              data memory not ready
//   pc_write, ifid_write  PC / IF/ID load enables
//   ifid_flush            IF/ID loads a NOP
//   idex_bubble           ID/EX control bits zeroed
//   pipe_hold             ID/EX and EX/MEM hold
//   state_o               FSM state for debug/checkers
//   wait_timeout          sticky: mem_wait run exceeded WAIT_MAX cycles
//   perf_*_cnt            (HAZ_PERF_EN only) stall / flush / hold cycle counts
//
// Optional feature macro: HAZ_PERF_EN (adds performance counters).
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int RA_W         = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int WAIT_MAX     = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_uses_rt,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_rt,
  input  logic            ex_branch_tkn,
  input  logic            mem_wait,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic            pipe_hold,
  output logic [1:0]      state_o,
`ifdef HAZ_PERF_EN
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt,
  output logic [31:0]     perf_wait_cnt,
`endif
  output logic            wait_timeout
);

  import pipe_pkg::*;

  localparam logic [2:0] FC_INIT  = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  hz_state_t  state, state_nxt;
  logic [2:0] fcnt, fcnt_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       timeout_nxt;
  logic       load_use;
  logic       ld_stall;

  // Register zero is hard-wired, so a load "to r0" creates no dependency.
  assign load_use = ex_mem_read && (ex_rt != RA_W'(REG_ZERO)) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      fcnt         <= '0;
      wcnt         <= '0;
      wait_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      fcnt         <= fcnt_nxt;
      wcnt         <= wcnt_nxt;
      wait_timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    fcnt_nxt    = fcnt;
    wcnt_nxt    = wcnt;
    timeout_nxt = wait_timeout;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    ld_stall    = 1'b0;

    if (mem_wait) begin
      // Whole pipe frozen: hazards are not evaluated against held stages,
      // and a pending flush keeps its remaining count.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      wcnt_nxt   = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
      if (wcnt == WAIT_LIM) begin
        timeout_nxt = 1'b1;
      end
      if (state != FLUSH) begin
        state_nxt = MWAIT;
      end
    end else begin
      wcnt_nxt = '0;
      if (state == FLUSH) begin
        // EX holds a bubble here, so branch and load-use inputs are ignored.
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (fcnt <= 3'd1) begin
          state_nxt = RUN;
          fcnt_nxt  = '0;
        end else begin
          fcnt_nxt = fcnt - 3'd1;
        end
      end else if (ex_branch_tkn) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nxt = FLUSH;
          fcnt_nxt  = FC_INIT;
        end else begin
          state_nxt = RUN;
        end
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        ld_stall    = 1'b1;
        state_nxt   = RUN;
      end else begin
        state_nxt = RUN;
      end
    end

    // While reset is asserted the pipe runs free with no squashing.
    if (!rst_n) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_hold   = 1'b0;
      ld_stall    = 1'b0;
    end
  end

  assign state_o = state;

`ifdef HAZ_PERF_EN
  hz_perf_cnt u_stall_cnt (.clk(clk), .rst_n(rst_n), .en(ld_stall),   .count(perf_stall_cnt));
  hz_perf_cnt u_flush_cnt (.clk(clk), .rst_n(rst_n), .en(ifid_flush), .count(perf_flush_cnt));
  hz_perf_cnt u_wait_cnt  (.clk(clk), .rst_n(rst_n), .en(pipe_hold),  .count(perf_wait_cnt));
`else
  logic unused_stall;
  assign unused_stall = ld_stall;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl: randomized + directed bench for pipe_hazard_ctrl.
// The driver issues one input set per cycle and pushes the reference
// model's expected outputs; a monitor pops and compares on the falling edge.
// Build with +define+HAZ_PERF_EN to include the performance counters.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int FC = 3;
  localparam int WM = 15;
`ifdef HAZ_PERF_EN
  localparam int W = 104;
`else
  localparam int W = 8;
`endif

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_branch_tkn = 1'b0, mem_wait = 1'b0;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, wait_timeout;
  logic [1:0] state_o;
`ifdef HAZ_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_wait_cnt;
`endif

  pipe_hazard_ctrl #(.RA_W(5), .FLUSH_CYCLES(FC), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_tkn(ex_branch_tkn),
    .mem_wait(mem_wait),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_hold(pipe_hold), .state_o(state_o),
`ifdef HAZ_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_wait_cnt(perf_wait_cnt),
`endif
    .wait_timeout(wait_timeout)
  );

  // ---- scoreboard ----
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc    = 0;

  // ---- reference model state (behavioural) ----
  int          m_flush_left = 0;   // forced squash cycles still owed
  int          m_run_len    = 0;   // consecutive mem_wait cycles so far
  logic        m_prev_wait  = 1'b0;
  logic        m_timeout    = 1'b0;
  logic [31:0] m_stall = '0, m_flush = '0, m_wait = '0;

  function automatic logic [W-1:0] pack(input logic pc, ifw, fl, bub, hold,
                                        input logic [1:0] st, input logic to);
    logic [7:0] core;
    core = {pc, ifw, fl, bub, hold, st, to};
`ifdef HAZ_PERF_EN
    return {core, m_stall, m_flush, m_wait};
`else
    return core;
`endif
  endfunction

  // ---- driver ----
  task automatic cycle(input logic rst, input logic mw, input logic br,
                       input logic emr, input logic [4:0] ert,
                       input logic [4:0] irs, input logic [4:0] irt,
                       input logic iurt);
    logic pc, ifw, fl, bub, hold, stall, lu;
    logic [1:0] st;
    @(posedge clk);
    #1;
    rst_n = !rst; mem_wait = mw; ex_branch_tkn = br; ex_mem_read = emr;
    ex_rt = ert; id_rs = irs; id_rt = irt; id_uses_rt = iurt;
    if (rst) begin
      m_flush_left = 0; m_run_len = 0; m_prev_wait = 1'b0; m_timeout = 1'b0;
      m_stall = '0; m_flush = '0; m_wait = '0;
      exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
      return;
    end
    st = (m_flush_left > 0) ? 2'd1 : (m_prev_wait ? 2'd2 : 2'd0);
    lu = emr && (ert != 5'd0) && ((ert == irs) || (iurt && (ert == irt)));
    pc = 1'b1; ifw = 1'b1; fl = 1'b0; bub = 1'b0; hold = 1'b0; stall = 1'b0;
    if (mw) begin
      pc = 1'b0; ifw = 1'b0; hold = 1'b1;
      m_run_len++;
    end else begin
      m_run_len = 0;
      if (m_flush_left > 0) begin
        fl = 1'b1; bub = 1'b1; m_flush_left--;
      end else if (br) begin
        fl = 1'b1; bub = 1'b1; m_flush_left = FC - 1;
      end else if (lu) begin
        pc = 1'b0; ifw = 1'b0; bub = 1'b1; stall = 1'b1;
      end
    end
    exp_q.push_back(pack(pc, ifw, fl, bub, hold, st, m_timeout));
    m_prev_wait = mw;
    if (m_run_len > WM) m_timeout = 1'b1;
    if (stall) m_stall++;
    if (fl)    m_flush++;
    if (hold)  m_wait++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Pull reset between edges and check the outputs respond without a clock.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (state_o !== 2'd0 || ifid_flush !== 1'b0 || idex_bubble !== 1'b0 ||
        pc_write !== 1'b1 || pipe_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got state=%0d flush=%b bubble=%b pc=%b hold=%b exp state=0 flush=0 bubble=0 pc=1 hold=0",
               state_o, ifid_flush, idex_bubble, pc_write, pipe_hold);
    end
`ifdef HAZ_PERF_EN
    n_checks++;
    if (perf_stall_cnt !== 0 || perf_flush_cnt !== 0 || perf_wait_cnt !== 0) begin
      n_fail++;
      $display("FAIL async_reset_perf got %0d/%0d/%0d exp 0/0/0",
               perf_stall_cnt, perf_flush_cnt, perf_wait_cnt);
    end
`endif
  endtask

  // ---- monitor ----
  always @(negedge clk) begin
    logic [W-1:0] exp_v, act_v;
    logic [7:0]   core;
    n_cyc++;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      core  = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, state_o, wait_timeout};
`ifdef HAZ_PERF_EN
      act_v = {core, perf_stall_cnt, perf_flush_cnt, perf_wait_cnt};
`else
      act_v = core;
`endif
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got=%h exp=%h (pc,ifw,flush,bubble,hold,state[2],timeout[,perf])",
                 n_cyc, act_v, exp_v);
      end
    end
  end

  // ---- stimulus ----
  initial begin
    int burst;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);

    // load-use: lw $5 then add using $5
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd2, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd2, 1'b1);
    // r0 never stalls; rt match only counts when rt is read
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1);

    // taken branch: three squash cycles
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(4);

    // mem_wait dominates branch and load-use, then the branch applies
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    idle(3);

    // mem_wait inside a flush freezes the flush count
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(3);

    // long wait: timeout then sticky after release
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(3);

    // reset in the middle of a flush
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(1);
    mid_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(2);

    // randomized traffic with occasional memory wait bursts
    burst = 0;
    for (int i = 0; i < 600; i++) begin
      logic mw;
      if (burst == 0 && $urandom_range(0, 99) < 8)
        burst = ($urandom_range(0, 9) == 0) ? 18 : $urandom_range(1, 6);
      mw = (burst > 0);
      if (burst > 0) burst--;
      cycle(1'b0, mw, ($urandom_range(0, 99) < 15), $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 299) == 0) begin
        mid_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      end
    end

    idle(1);
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
